// File: rtl/arr_feeder.sv
// ---------------------------------------------------------------------------
// arr_feeder
//
// Feeds one job into an arrStation chain. The feeder holds one A-vector and
// one B-vector of SIZE words. When a job starts it pulses the station clear,
// streams the SIZE (A,B) pairs, and waits for the station's result. The
// result is captured and reported with a one-cycle done pulse. A cycle-count
// guard ends the wait if the station never answers.
//
// Data words are fp32 bit patterns. They are buffered and passed through
// without any arithmetic.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   ld_we/ld_addr     load strobe and buffer index (writes only while IDLE)
//   ld_a/ld_b         A and B words stored at ld_addr
//   start             begin a job (looked at only while IDLE)
//   busy              high while a job is in flight
//   done              one-cycle pulse at the end of a job
//   result_out        last captured result (0 after a timeout)
//   timeout_err       qualifies done; stays set until the next start
//   st_g_rst          clear pulse to the station
//   st_dataA/B        operand words to the station
//   st_dataReady      operand-valid strobe to the station
//   st_result         result word from the station
//   st_result_ready   result-valid from the station (sticky until cleared)
// ---------------------------------------------------------------------------
module arr_feeder #(
   parameter int SIZE    = 4,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_we,
   input  logic [$clog2(SIZE)-1:0]   ld_addr,
   input  logic [DATA_W-1:0]         ld_a,
   input  logic [DATA_W-1:0]         ld_b,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_W-1:0]         result_out,
   output logic                      timeout_err,
   output logic                      st_g_rst,
   output logic [DATA_W-1:0]         st_dataA,
   output logic [DATA_W-1:0]         st_dataB,
   output logic                      st_dataReady,
   input  logic [DATA_W-1:0]         st_result,
   input  logic                      st_result_ready
);

   // The index counter has one extra bit so that "all SIZE pairs sent" can
   // be seen as idx == SIZE without wrapping back to 0.
   localparam int IW = $clog2(SIZE) + 1;
   // TIMEOUT may be as large as 65535.
   localparam int TW = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state;
   logic [IW-1:0]       idx;
   logic [TW-1:0]       tcnt;

   logic [DATA_W-1:0]   buf_a [SIZE];
   logic [DATA_W-1:0]   buf_b [SIZE];

   logic                ld_ok;

   // Writes are accepted only in IDLE. This keeps the vectors of a running
   // job stable even if the host keeps writing.
   assign ld_ok = ld_we && (state == S_IDLE) && ({1'b0, ld_addr} < IW'(SIZE));

   // Vector buffers: reset leaves them alone so a job can be re-run after
   // an abort without reloading.
   always_ff @(posedge clk) begin
      if (ld_ok) begin
         buf_a[ld_addr] <= ld_a;
         buf_b[ld_addr] <= ld_b;
      end
   end

   // Control FSM. Every output is a register that is written here. Each
   // output therefore reflects the decision made in the state one cycle
   // earlier.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         tcnt         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_err  <= 1'b0;
         result_out   <= '0;
         st_g_rst     <= 1'b0;
         st_dataReady <= 1'b0;
         st_dataA     <= '0;
         st_dataB     <= '0;
      end else begin
         // These two are pulses. Only their own states raise them.
         st_g_rst <= 1'b0;
         done     <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_CLEAR;
                  busy        <= 1'b1;
                  timeout_err <= 1'b0;
                  idx         <= '0;
               end
            end

            // One-cycle clear pulse. The station also drops any sticky
            // ready that is left over from the previous job.
            S_CLEAR: begin
               st_g_rst     <= 1'b1;
               st_dataReady <= 1'b0;
               idx          <= '0;
               state        <= S_STREAM;
            end

            // One pair per cycle with no gaps. The operand registers keep
            // the last pair after the strobe drops.
            S_STREAM: begin
               if (idx == IW'(SIZE)) begin
                  st_dataReady <= 1'b0;
                  tcnt         <= '0;
                  state        <= S_WAIT;
               end else begin
                  st_dataReady <= 1'b1;
                  st_dataA     <= buf_a[idx[IW-2:0]];
                  st_dataB     <= buf_b[idx[IW-2:0]];
                  idx          <= idx + 1'b1;
               end
            end

            // If ready and the timeout limit occur in the same cycle, ready
            // wins. A result that arrives on the last allowed cycle is
            // therefore still delivered.
            S_WAIT: begin
               if (st_result_ready) begin
                  result_out  <= st_result;
                  timeout_err <= 1'b0;
                  state       <= S_DONE;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  result_out  <= '0;
                  timeout_err <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            // done and the fall of busy appear together. start is not
            // looked at here, so a start that overlaps the end of a job is
            // dropped rather than queued.
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arr_feeder.sv
module tb_arr_feeder;

   localparam int SIZE = 4;
   localparam int DW   = 32;
   localparam int TMO  = 8;
   localparam int AW   = $clog2(SIZE);

   logic            clk;
   logic            rst;
   logic            ld_we;
   logic [AW-1:0]   ld_addr;
   logic [DW-1:0]   ld_a;
   logic [DW-1:0]   ld_b;
   logic            start;
   logic            busy;
   logic            done;
   logic [DW-1:0]   result_out;
   logic            timeout_err;
   logic            st_g_rst;
   logic [DW-1:0]   st_dataA;
   logic [DW-1:0]   st_dataB;
   logic            st_dataReady;
   logic [DW-1:0]   st_result = '0;
   logic            st_result_ready = 1'b0;

   int checks   = 0;
   int failures = 0;

   arr_feeder #(.SIZE(SIZE), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_a(ld_a), .ld_b(ld_b), .start(start), .busy(busy), .done(done),
      .result_out(result_out), .timeout_err(timeout_err),
      .st_g_rst(st_g_rst), .st_dataA(st_dataA), .st_dataB(st_dataB),
      .st_dataReady(st_dataReady), .st_result(st_result),
      .st_result_ready(st_result_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fp32 helpers for the small non-negative integers used as operands
   function automatic logic [31:0] i2f(input int n);
      int p;
      logic [31:0] w;
      if (n <= 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 24; i++) if ((n >> i) != 0) p = i;
      w = 32'(n << (23 - p));
      return {1'b0, 8'(127 + p), w[22:0]};
   endfunction

   function automatic int f2i(input logic [31:0] w);
      int e;
      longint m;
      e = int'(w[30:23]);
      if (e < 127) return 0;
      e = e - 127;
      if (e > 30) return 32'h7fffffff;
      m = longint'({1'b1, w[22:0]});
      if (e >= 23) return int'(m << (e - 23));
      return int'(m >> (23 - e));
   endfunction

   // Behavioural station: sum of products, sticky ready lat cycles after last pair
   int st_lat = 6;
   int acc = 0, cnt = 0, cd = 0;
   always @(posedge clk) begin
      if (st_g_rst) begin
         acc = 0; cnt = 0; cd = 0;
         st_result_ready <= 1'b0;
         st_result <= '0;
      end else if (st_dataReady) begin
         acc = acc + f2i(st_dataA) * f2i(st_dataB);
         cnt = cnt + 1;
         if (cnt == SIZE && st_lat > 0) cd = st_lat;
      end else if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) begin
            st_result_ready <= 1'b1;
            st_result <= i2f(acc);
         end
      end
   end

   // Reference model of the feeder: buffer contents and job timing
   int          ref_ai [SIZE];
   int          ref_bi [SIZE];
   logic [31:0] ref_aw [SIZE];
   logic [31:0] ref_bw [SIZE];

   // The station answers at edge R = SIZE+2+lat. The feeder can see the
   // answer from the first WAIT decision edge (SIZE+3) up to the last one
   // (SIZE+2+TMO). done follows the deciding edge by one cycle.
   function automatic int exp_done(input int lat);
      int r, e;
      r = (lat > 0) ? SIZE + 2 + lat : 1000000;
      e = (r + 1 > SIZE + 3) ? r + 1 : SIZE + 3;
      if (e <= SIZE + 2 + TMO) return e + 1;
      return SIZE + 3 + TMO;
   endfunction

   function automatic bit exp_timeout(input int lat);
      int r;
      r = (lat > 0) ? SIZE + 2 + lat : 1000000;
      return (r + 1 > SIZE + 2 + TMO);
   endfunction

   function automatic logic [31:0] exp_result(input int lat);
      int s;
      if (exp_timeout(lat)) return 32'h0;
      s = 0;
      for (int k = 0; k < SIZE; k++) s += ref_ai[k] * ref_bi[k];
      return i2f(s);
   endfunction

   function automatic logic [127:0] exp_rdy_mask();
      logic [127:0] m;
      m = '0;
      for (int k = 0; k < SIZE; k++) m[2 + k] = 1'b1;
      return m;
   endfunction

   // Observations of one job
   logic [127:0] obs_grst, obs_rdy;
   logic [31:0]  obs_a [128];
   logic [31:0]  obs_b [128];
   int           obs_done_cnt, obs_done_cyc;
   logic [31:0]  obs_result, obs_last_a, obs_last_b;
   logic         obs_err, obs_err_c1, obs_busy_at_done, obs_busy_after;
   int           sbad;

   task automatic load_vec(input int k, input int av, input int bv);
      ld_we = 1'b1; ld_addr = AW'(k); ld_a = i2f(av); ld_b = i2f(bv);
      @(posedge clk); #1;
      ld_we = 1'b0;
      ref_ai[k] = av; ref_bi[k] = bv; ref_aw[k] = i2f(av); ref_bw[k] = i2f(bv);
   endtask

   task automatic load_random();
      for (int k = 0; k < SIZE; k++) load_vec(k, int'($urandom_range(1, 15)), int'($urandom_range(1, 15)));
   endtask

   // Runs one job from the start edge (cycle 0) and records what the DUT did
   task automatic run_job(input int lat, input bit poke);
      st_lat = lat;
      obs_grst = '0; obs_rdy = '0; obs_done_cnt = 0; obs_done_cyc = -1;
      obs_result = 'x; obs_err = 1'bx; obs_busy_at_done = 1'bx; obs_busy_after = 1'bx;
      obs_err_c1 = 1'bx; obs_last_a = 'x; obs_last_b = 'x;
      for (int i = 0; i < 128; i++) begin obs_a[i] = 'x; obs_b[i] = 'x; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk); #1;
         if (n == 1) obs_err_c1 = timeout_err;
         if (st_g_rst) obs_grst[n] = 1'b1;
         if (st_dataReady) begin obs_rdy[n] = 1'b1; obs_a[n] = st_dataA; obs_b[n] = st_dataB; end
         if (obs_done_cyc >= 0 && n == obs_done_cyc + 1) begin
            obs_busy_after = busy;
            break;
         end
         if (done) begin
            obs_done_cnt++;
            if (obs_done_cyc < 0) begin
               obs_done_cyc = n; obs_result = result_out; obs_err = timeout_err;
               obs_busy_at_done = busy; obs_last_a = st_dataA; obs_last_b = st_dataB;
            end
         end
         if (poke && busy && !done) begin
            start = 1'b1; ld_we = 1'b1;
            ld_addr = AW'($urandom_range(0, SIZE - 1));
            ld_a = $urandom; ld_b = $urandom;
         end else begin
            start = 1'b0; ld_we = 1'b0;
         end
      end
      start = 1'b0; ld_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_a = '0; ld_b = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
      checks++; if (st_g_rst !== 1'b0) begin failures++; $display("FAIL reset_g_rst: got %b want 0", st_g_rst); end
      checks++; if (st_dataReady !== 1'b0) begin failures++; $display("FAIL reset_dataReady: got %b want 0", st_dataReady); end
      checks++; if (result_out !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 0", result_out); end
      checks++; if ({st_dataA, st_dataB} !== 64'h0) begin failures++; $display("FAIL reset_data: got %h/%h want 0/0", st_dataA, st_dataB); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      for (int k = 0; k < SIZE; k++) load_vec(k, k + 1, 1);
      run_job(6, 1'b0);
      checks++; if (obs_grst !== (128'b1 << 1)) begin failures++; $display("FAIL basic_g_rst: got %h want %h", obs_grst, 128'b1 << 1); end
      checks++; if (obs_rdy !== exp_rdy_mask()) begin failures++; $display("FAIL basic_ready_cycles: got %h want %h", obs_rdy, exp_rdy_mask()); end
      sbad = 0;
      for (int k = 0; k < SIZE; k++) if (obs_a[2 + k] !== ref_aw[k] || obs_b[2 + k] !== ref_bw[k]) sbad++;
      checks++; if (sbad != 0) begin failures++; $display("FAIL basic_stream: %0d pairs wrong, A[0] got %h want %h", sbad, obs_a[2], ref_aw[0]); end
      checks++; if (obs_done_cyc != exp_done(6)) begin failures++; $display("FAIL basic_done_cycle: got %0d want %0d", obs_done_cyc, exp_done(6)); end
      checks++; if (obs_done_cnt != 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", obs_done_cnt); end
      checks++; if (obs_result !== 32'h41200000) begin failures++; $display("FAIL basic_result: got %h want 41200000", obs_result); end
      checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL basic_timeout_err: got %b want 0", obs_err); end
      checks++; if (obs_busy_at_done !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b want 0", obs_busy_at_done); end
      checks++; if (obs_last_a !== ref_aw[SIZE - 1] || obs_last_b !== ref_bw[SIZE - 1]) begin failures++; $display("FAIL basic_data_hold: got %h/%h want %h/%h", obs_last_a, obs_last_b, ref_aw[SIZE - 1], ref_bw[SIZE - 1]); end
   endtask

   task automatic test_timeout();
      load_random();
      run_job(0, 1'b0);
      checks++; if (obs_done_cyc != SIZE + 3 + TMO) begin failures++; $display("FAIL timeout_done_cycle: got %0d want %0d", obs_done_cyc, SIZE + 3 + TMO); end
      checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL timeout_err: got %b want 1", obs_err); end
      checks++; if (obs_result !== 32'h0) begin failures++; $display("FAIL timeout_result: got %h want 0", obs_result); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_hold: got %b want 1", timeout_err); end
      // One cycle too late for the last WAIT decision
      run_job(TMO, 1'b0);
      checks++; if (obs_err_c1 !== 1'b0) begin failures++; $display("FAIL timeout_err_clear_on_start: got %b want 0", obs_err_c1); end
      checks++; if (obs_done_cyc != exp_done(TMO) || obs_err !== exp_timeout(TMO)) begin failures++; $display("FAIL timeout_late_ready: got cyc %0d err %b want cyc %0d err %b", obs_done_cyc, obs_err, exp_done(TMO), exp_timeout(TMO)); end
   endtask

   task automatic test_tie();
      load_random();
      run_job(TMO - 1, 1'b0);
      checks++; if (obs_done_cyc != exp_done(TMO - 1)) begin failures++; $display("FAIL tie_done_cycle: got %0d want %0d", obs_done_cyc, exp_done(TMO - 1)); end
      checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL tie_timeout_err: got %b want 0", obs_err); end
      checks++; if (obs_result !== exp_result(TMO - 1)) begin failures++; $display("FAIL tie_result: got %h want %h", obs_result, exp_result(TMO - 1)); end
   endtask

   task automatic test_busy_ignore();
      load_random();
      run_job(6, 1'b1);
      sbad = 0;
      for (int k = 0; k < SIZE; k++) if (obs_a[2 + k] !== ref_aw[k] || obs_b[2 + k] !== ref_bw[k]) sbad++;
      checks++; if (sbad != 0) begin failures++; $display("FAIL busy_stream: %0d pairs wrong", sbad); end
      checks++; if (obs_grst !== (128'b1 << 1) || obs_done_cnt != 1) begin failures++; $display("FAIL busy_restart: g_rst %h done_count %0d want %h 1", obs_grst, obs_done_cnt, 128'b1 << 1); end
      checks++; if (obs_busy_after !== 1'b0) begin failures++; $display("FAIL busy_start_in_done: busy after done got %b want 0", obs_busy_after); end
      run_job(6, 1'b0);
      sbad = 0;
      for (int k = 0; k < SIZE; k++) if (obs_a[2 + k] !== ref_aw[k] || obs_b[2 + k] !== ref_bw[k]) sbad++;
      checks++; if (sbad != 0) begin failures++; $display("FAIL busy_buffers_kept: %0d pairs wrong", sbad); end
      checks++; if (obs_result !== exp_result(6)) begin failures++; $display("FAIL busy_next_result: got %h want %h", obs_result, exp_result(6)); end
   endtask

   task automatic test_rst_mid();
      int dn;
      logic bsy;
      load_random();
      st_lat = 6;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (st_dataReady !== 1'b0) begin failures++; $display("FAIL rstmid_dataReady: got %b want 0", st_dataReady); end
      checks++; if (st_dataA !== 32'h0) begin failures++; $display("FAIL rstmid_dataA: got %h want 0", st_dataA); end
      dn = 0; bsy = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (done) dn++;
         if (busy) bsy = 1'b1;
      end
      checks++; if (dn != 0 || bsy !== 1'b0) begin failures++; $display("FAIL rstmid_no_done: done pulses %0d busy %b want 0 0", dn, bsy); end
      run_job(6, 1'b0);
      sbad = 0;
      for (int k = 0; k < SIZE; k++) if (obs_a[2 + k] !== ref_aw[k] || obs_b[2 + k] !== ref_bw[k]) sbad++;
      checks++; if (sbad != 0 || obs_rdy !== exp_rdy_mask()) begin failures++; $display("FAIL rstmid_restream: %0d pairs wrong, ready %h want %h", sbad, obs_rdy, exp_rdy_mask()); end
      checks++; if (obs_result !== exp_result(6) || obs_done_cyc != exp_done(6)) begin failures++; $display("FAIL rstmid_rejob: got %h at %0d want %h at %0d", obs_result, obs_done_cyc, exp_result(6), exp_done(6)); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < SIZE; k++) load_vec(k, k + 1, int'($urandom_range(1, 15)));
      run_job(6, 1'b0);
      checks++; if (obs_result !== exp_result(6)) begin failures++; $display("FAIL b2b_job1_result: got %h want %h", obs_result, exp_result(6)); end
      for (int k = 0; k < SIZE; k++) load_vec(k, k + 1, 2);
      run_job(6, 1'b0);
      checks++; if (obs_result !== 32'h41A00000) begin failures++; $display("FAIL b2b_job2_result: got %h want 41A00000", obs_result); end
      checks++; if (obs_done_cyc != exp_done(6)) begin failures++; $display("FAIL b2b_job2_done_cycle: got %0d want %0d", obs_done_cyc, exp_done(6)); end
      // Immediate restart with no reload: same data, same answer
      run_job(3, 1'b0);
      checks++; if (obs_result !== exp_result(3) || obs_done_cyc != exp_done(3)) begin failures++; $display("FAIL b2b_job3: got %h at %0d want %h at %0d", obs_result, obs_done_cyc, exp_result(3), exp_done(3)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_tie();
      test_busy_ignore();
      test_rst_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arr_feeder.md
Name: arr_feeder

Overview:
- Source-side driver for an arrStation chain. Holds one A-vector and one B-vector of SIZE fp32 words, loaded through a write port.
- On start, clears the station with a g_rst pulse, then streams the SIZE (A,B) pairs on dataA/dataB/dataReady.
- Waits for the station's resultOutReady, captures result, and reports done, with a timeout guard.
- Pure control and buffering; no arithmetic on data words.

Parameters:
SIZE, 4, vector length streamed per job (must match station SIZE; 2..8)
DATA_W, 32, word width (fp32 bit pattern, passed through untouched)
TIMEOUT, 255, max cycles spent in WAIT before abort (1..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ld_we  in  1  load strobe for vector buffers
ld_addr  in  clog2(SIZE)  buffer index
ld_a  in  DATA_W  A word to store at ld_addr
ld_b  in  DATA_W  B word to store at ld_addr
start  in  1  start a job (sampled in IDLE only)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job end
result_out  out  DATA_W  captured result, held until next done
timeout_err  out  1  valid with done; 1 = timed out
st_g_rst  out  1  clear pulse to station g_rst
st_dataA  out  DATA_W  to station dataA
st_dataB  out  DATA_W  to station dataB
st_dataReady  out  1  to station dataReady
st_result  in  DATA_W  from station result
st_result_ready  in  1  from station resultOutReady (sticky high)

Behaviour:
- Reset state (rst=1 at a clk edge):
  - state IDLE.
  - busy, done, timeout_err, st_g_rst, st_dataReady = 0.
  - result_out, st_dataA, st_dataB = 0.
  - Index and timeout counters = 0.
  - Buffer contents are not cleared.
- All outputs are registered.
- rst mid-job aborts immediately: no done pulse, and st_dataReady drops on the next edge.
- Load port:
  - ld_we=1 in IDLE writes A[ld_addr]=ld_a and B[ld_addr]=ld_b.
  - ld_we is ignored when busy=1.
  - ld_addr >= SIZE is ignored.
- FSM states, with cycle 0 = edge where start=1 is sampled in IDLE:
  - IDLE: start=1 -> CLEAR. start while busy is ignored, not queued.
  - CLEAR: st_g_rst=1 for exactly 1 cycle (cycle 1), st_dataReady=0 -> STREAM.
  - STREAM: cycles 2..SIZE+1.
    - st_dataReady=1, st_dataA=A[k], st_dataB=B[k] at cycle 2+k, k=0..SIZE-1.
    - Contiguous, no gaps.
    - After k=SIZE-1 -> WAIT. st_dataReady=0 from cycle SIZE+2.
    - st_dataA/st_dataB hold their last value.
  - WAIT: timeout counter starts at 0 on entry and increments every cycle in WAIT.
    - If st_result_ready=1: result_out<=st_result, timeout_err<=0, -> DONE.
    - Else if counter==TIMEOUT-1: result_out<=0, timeout_err<=1, -> DONE.
    - Ready has priority if both occur the same cycle.
  - DONE: done=1 for 1 cycle, busy=0 in the same cycle as done -> IDLE.
    - timeout_err holds until the next start.
    - start sampled during DONE is ignored.
- st_result_ready is ignored outside WAIT. A stale sticky ready from a previous job is cleared by the station on the CLEAR pulse, one cycle before STREAM.
- Index counter width is clog2(SIZE)+1. No wrap-around within a job; it is reset to 0 on entering CLEAR.
- Job latency without timeout: done is at cycle SIZE+3+(station latency after last pair) at minimum.
- Back-to-back jobs:
  - start may be asserted the cycle done is high, but is sampled only in IDLE.
  - Minimum gap is 1 idle cycle.
  - Buffers may be reloaded between jobs.

Test Plan:
1. Load A=[3F800000,40000000,40400000,40800000], B=[3F800000 x4]; start; behavioural station model (sum of products, ready 6 cycles after last pair):
   - st_g_rst at cycle 1 only.
   - st_dataReady at cycles 2-5 with A[k] at cycle 2+k.
   - done pulse with result_out=41200000 (10.0), timeout_err=0.
2. Timeout: TIMEOUT=8, station model never asserts ready -> done at cycle SIZE+2+8+1=15 (SIZE=4), timeout_err=1, result_out=00000000.
3. Ready and timeout on the same WAIT cycle -> timeout_err=0, result_out=st_result.
4. start and ld_we pulsed while busy -> no restart, buffers unchanged; the next job streams the original data.
5. rst asserted at cycle 3 (mid-STREAM) -> next cycle busy=0, st_dataReady=0, st_dataA=0; no done pulse; fresh start afterwards runs a full, correct job.
6. Two back-to-back jobs with reload between (second B=[40000000 x4]) -> second result 41A00000 (20.0). A sticky ready left over from job 1 is not captured before job 2's WAIT.
